// File: rtl/merge_sort_sequencer.sv
// merge_sort_sequencer
//   Bottom-up merge sort controller. Owns a local word buffer and sorts it
//   in place by streaming pairs of adjacent sorted runs (width 1, 2, 4, ...)
//   into a two-FIFO merge core, then draining the merged result back into
//   the buffer.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   load_en/addr/data       host buffer write (ignored while busy)
//   sort_start, sort_len    start request and word count (0..DEPTH)
//   rd_addr, rd_data        host buffer read, 1-cycle registered latency
//   busy, sort_done, err    status: running, completion pulse, sticky timeout
//   core_*                  merge core handshake: FIFO writes, start/done,
//                           merged FIFO read (first-word-fall-through)

module merge_sort_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              sort_start,
  input  logic [ADDR_W:0]   sort_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              sort_done,
  output logic              err,
  output logic              core_start,
  output logic [DATA_W-1:0] core_fifo_wr_data,
  output logic              core_fifo1_wr_en,
  output logic              core_fifo2_wr_en,
  output logic              core_merged_rd_en,
  input  logic [DATA_W-1:0] core_merged_rd_data,
  input  logic              core_done
);

  localparam int LW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_FILL, S_START, S_WAIT,
    S_DRAIN, S_RELEASE, S_NEXT, S_DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Run arithmetic is one bit wider than the address so w can reach DEPTH.
  logic [LW-1:0] w, base, len, len_a, len_b, cnt;
  logic [TW-1:0] tmo;

  logic [LW-1:0]     total, remain, remain_b, setup_a, setup_b, w2, base_next;
  logic [ADDR_W-1:0] mem_ptr, rd_sel;

  assign total     = len_a + len_b;
  assign remain    = len - base;
  assign setup_a   = (w < remain) ? w : remain;
  assign remain_b  = remain - setup_a;
  assign setup_b   = (w < remain_b) ? w : remain_b;
  assign w2        = w << 1;
  assign base_next = base + w2;
  assign mem_ptr   = ADDR_W'(base + cnt);

  // One read port shared by host and sequencer; the owner follows busy.
  assign rd_sel            = busy ? mem_ptr : rd_addr;
  assign rd_data           = rd_q;
  assign core_fifo_wr_data = rd_q;

  // Buffer writes: host loads while idle, merged words while draining.
  always_ff @(posedge clock) begin
    if (!busy && load_en)
      mem[load_addr] <= load_data;
    else if (core_merged_rd_en)
      mem[mem_ptr] <= core_merged_rd_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= mem[rd_sel];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      sort_done         <= 1'b0;
      err               <= 1'b0;
      core_start        <= 1'b0;
      core_fifo1_wr_en  <= 1'b0;
      core_fifo2_wr_en  <= 1'b0;
      core_merged_rd_en <= 1'b0;
      w                 <= '0;
      base              <= '0;
      len               <= '0;
      len_a             <= '0;
      len_b             <= '0;
      cnt               <= '0;
      tmo               <= '0;
    end else begin
      sort_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sort_start) begin
            len   <= sort_len;
            w     <= LW'(1);
            base  <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= (sort_len <= LW'(1)) ? S_DONE : S_SETUP;
          end
        end
        S_SETUP: begin
          len_a <= setup_a;
          len_b <= setup_b;
          cnt   <= '0;
          state <= (setup_b == '0) ? S_NEXT : S_FILL;
        end
        S_FILL: begin
          // Read data appears one cycle after the address, so the enables
          // are registered alongside it and the last write lands in the
          // extra cycle where cnt == total.
          if (cnt < total) begin
            core_fifo1_wr_en <= (cnt < len_a);
            core_fifo2_wr_en <= !(cnt < len_a);
            cnt              <= cnt + LW'(1);
          end else begin
            core_fifo1_wr_en <= 1'b0;
            core_fifo2_wr_en <= 1'b0;
            core_start       <= 1'b1;
            state            <= S_START;
          end
        end
        S_START: begin
          tmo   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            cnt               <= '0;
            core_merged_rd_en <= 1'b1;
            state             <= S_DRAIN;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            core_start <= 1'b0;
            state      <= S_DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == total - LW'(1)) begin
            core_merged_rd_en <= 1'b0;
            core_start        <= 1'b0;
            state             <= S_RELEASE;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        S_RELEASE: begin
          if (!core_done) state <= S_NEXT;
        end
        S_NEXT: begin
          if (base_next >= len) begin
            w     <= w2;
            base  <= '0;
            state <= (w2 >= len) ? S_DONE : S_SETUP;
          end else begin
            base  <= base_next;
            state <= S_SETUP;
          end
        end
        S_DONE: begin
          sort_done <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_sort_sequencer.sv
// tb_merge_sort_sequencer
//   Self-checking bench for merge_sort_sequencer. A behavioural merge core
//   (queues) sits under the DUT; expected buffer contents come from a plain
//   insertion sort of the loaded words, and expected merge counts from
//   walking the run-pair schedule arithmetically.

module tb_merge_sort_sequencer;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4096;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              sort_start;
  logic [ADDR_W:0]   sort_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy, sort_done, err, core_start;
  logic [DATA_W-1:0] core_fifo_wr_data;
  logic              core_fifo1_wr_en, core_fifo2_wr_en, core_merged_rd_en;
  logic [DATA_W-1:0] core_merged_rd_data;
  logic              core_done;

  merge_sort_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .sort_start(sort_start), .sort_len(sort_len),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .sort_done(sort_done), .err(err),
    .core_start(core_start), .core_fifo_wr_data(core_fifo_wr_data),
    .core_fifo1_wr_en(core_fifo1_wr_en), .core_fifo2_wr_en(core_fifo2_wr_en),
    .core_merged_rd_en(core_merged_rd_en),
    .core_merged_rd_data(core_merged_rd_data), .core_done(core_done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Behavioural merge core: two input queues, merged on the rising edge of
  // core_start, done raised a few cycles later and held while start is high.
  logic [DATA_W-1:0] q1[$], q2[$], qm[$];
  int   core_starts = 0;
  logic core_stall  = 1'b0;
  logic core_flush  = 1'b0;
  int   lat;
  logic start_prev;

  function automatic void doMerge();
    while (q1.size() > 0 || q2.size() > 0) begin
      if (q2.size() == 0 || (q1.size() > 0 && q1[0] <= q2[0]))
        qm.push_back(q1.pop_front());
      else
        qm.push_back(q2.pop_front());
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q1.delete(); q2.delete(); qm.delete();
      lat        = 0;
      start_prev = 1'b0;
      core_done           <= 1'b0;
      core_merged_rd_data <= '0;
    end else begin
      if (core_flush) begin
        q1.delete(); q2.delete(); qm.delete();
      end
      if (core_fifo1_wr_en) q1.push_back(core_fifo_wr_data);
      if (core_fifo2_wr_en) q2.push_back(core_fifo_wr_data);
      if (core_merged_rd_en && qm.size() > 0) void'(qm.pop_front());
      if (core_start && !start_prev) begin
        core_starts++;
        if (!core_stall) begin
          doMerge();
          lat = 3;
        end
      end
      if (!core_start) begin
        core_done <= 1'b0;
        lat = 0;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) core_done <= 1'b1;
      end
      start_prev = core_start;
      core_merged_rd_data <= (qm.size() > 0) ? qm[0] : '0;
    end
  end

  int done_pulses = 0;
  always @(negedge clock) if (sort_done === 1'b1) done_pulses++;

  // Reference model data
  logic [DATA_W-1:0] stim [DEPTH];
  logic [DATA_W-1:0] expv [DEPTH];

  function automatic void refSort(input int n);
    logic [DATA_W-1:0] key;
    int j;
    for (int i = 0; i < n; i++) expv[i] = stim[i];
    for (int i = 1; i < n; i++) begin
      key = expv[i];
      j = i - 1;
      while (j >= 0 && expv[j] > key) begin
        expv[j+1] = expv[j];
        j--;
      end
      expv[j+1] = key;
    end
  endfunction

  // Number of run pairs that actually need the core (run B non-empty).
  function automatic int expStarts(input int n);
    int c = 0;
    for (int w = 1; w < n; w *= 2)
      for (int b = 0; b < n; b += 2 * w)
        if (b + w < n) c++;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] expd);
    tests++;
    assert (obs === expd) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Loads stim[0..n-1]; the last word is written in the same cycle as
  // sort_start. Waits for sort_done within the budget.
  task automatic applyStimulus(input int n, input int budget, output int cyc);
    for (int i = 0; i < n - 1; i++) begin
      @(negedge clock);
      load_en = 1'b1; load_addr = ADDR_W'(i); load_data = stim[i];
    end
    @(negedge clock);
    load_en = (n > 0); load_addr = ADDR_W'(n - 1); load_data = stim[(n > 0) ? n - 1 : 0];
    sort_start = 1'b1; sort_len = (ADDR_W+1)'(n);
    @(negedge clock);
    load_en = 1'b0; sort_start = 1'b0;
    cyc = 1;
    while (sort_done !== 1'b1 && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic runSortCheck(input string tag, input int n, input int budget);
    int cyc, s0, p0;
    s0 = core_starts;
    p0 = done_pulses;
    refSort(n);
    applyStimulus(n, budget, cyc);
    checkOutput({tag, "_done_seen"}, sort_done, 1'b1);
    checkOutput({tag, "_err"}, err, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput({tag, "_busy_after"}, busy, 1'b0);
    checkOutput({tag, "_done_pulses"}, 32'(done_pulses - p0), 32'd1);
    checkOutput({tag, "_core_starts"}, 32'(core_starts - s0), 32'(expStarts(n)));
    for (int i = 0; i < n; i++) begin
      rd_addr = ADDR_W'(i);
      @(negedge clock);
      checkOutput($sformatf("%s_word%0d", tag, i), rd_data, expv[i]);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_sort_done"}, sort_done, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
    checkOutput({tag, "_core_start"}, core_start, 1'b0);
    checkOutput({tag, "_fifo1_wr"}, core_fifo1_wr_en, 1'b0);
    checkOutput({tag, "_fifo2_wr"}, core_fifo2_wr_en, 1'b0);
    checkOutput({tag, "_merged_rd"}, core_merged_rd_en, 1'b0);
    checkOutput({tag, "_rd_data"}, rd_data, '0);
  endtask

  initial begin
    int cyc, s0, n;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    sort_start = 1'b0; sort_len = '0; rd_addr = '0;
    repeat (3) @(negedge clock);
    checkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Four words, three merges
    stim[0] = 5; stim[1] = 3; stim[2] = 8; stim[3] = 1;
    runSortCheck("len4", 4, 2000);

    // Odd length: the lone word at base 4 is skipped in the first pass
    stim[0] = 9; stim[1] = 7; stim[2] = 5; stim[3] = 3; stim[4] = 1;
    runSortCheck("len5", 5, 2000);

    // Trivial lengths finish without touching the core
    for (int k = 0; k < 2; k++) begin
      s0 = core_starts;
      @(negedge clock);
      sort_start = 1'b1; sort_len = (ADDR_W+1)'(k);
      @(negedge clock);
      sort_start = 1'b0;
      checkOutput($sformatf("len%0d_busy", k), busy, 1'b1);
      checkOutput($sformatf("len%0d_done_c1", k), sort_done, 1'b0);
      @(negedge clock);
      checkOutput($sformatf("len%0d_done_c2", k), sort_done, 1'b1);
      @(negedge clock);
      checkOutput($sformatf("len%0d_done_c3", k), sort_done, 1'b0);
      checkOutput($sformatf("len%0d_idle", k), busy, 1'b0);
      checkOutput($sformatf("len%0d_no_core", k), 32'(core_starts - s0), 32'd0);
    end

    // Full buffer, descending with duplicate extremes
    for (int i = 0; i < DEPTH; i++) stim[i] = 32'(DEPTH - 1 - i);
    stim[0] = 32'hFFFF_FFFF; stim[1] = 32'h0; stim[7] = 32'hFFFF_FFFF; stim[100] = 32'h0;
    runSortCheck("full", DEPTH, 40000);

    // Random lengths and data, some with a narrow value range for ties
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2, 40);
      for (int i = 0; i < n; i++)
        stim[i] = (r == 1) ? 32'($urandom_range(0, 7)) : 32'($urandom);
      runSortCheck($sformatf("rand%0d", r), n, 5000);
    end

    // Stalled core: timeout raises err and still completes
    core_stall = 1'b1;
    stim[0] = 2; stim[1] = 1;
    applyStimulus(2, TIMEOUT + 200, cyc);
    checkOutput("tmo_done_seen", sort_done, 1'b1);
    checkOutput("tmo_err", err, 1'b1);
    checkOutput("tmo_core_start", core_start, 1'b0);
    checkOutput("tmo_wait_len", 32'(cyc >= TIMEOUT), 32'd1);
    repeat (3) @(negedge clock);
    checkOutput("tmo_err_sticky", err, 1'b1);
    core_flush = 1'b1;
    @(negedge clock);
    core_flush = 1'b0;
    core_stall = 1'b0;
    stim[0] = 7; stim[1] = 4;
    runSortCheck("after_tmo", 2, 2000);

    // Reset while draining aborts at once; a fresh sort then works
    for (int i = 0; i < 8; i++) stim[i] = 32'($urandom);
    refSort(8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      load_en = 1'b1; load_addr = ADDR_W'(i); load_data = stim[i];
    end
    @(negedge clock);
    load_en = 1'b0; sort_start = 1'b1; sort_len = 9'd8;
    @(negedge clock);
    sort_start = 1'b0;
    cyc = 0;
    while (core_merged_rd_en !== 1'b1 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("drain_reached", core_merged_rd_en, 1'b1);
    reset = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) stim[i] = 32'($urandom);
    runSortCheck("post_reset", 8, 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
